hilo_md_unit: RTL and testbench

//  E-stage multiply/divide unit of the 5-stage MIPS pipeline; owns the HI/LO registers.

---
 rtl/hilo_pkg.sv | 29 ++
 rtl/md_datapath.sv | 60 ++++++
 rtl/hilo_md_unit.sv | 89 ++++++++
 tb/tb_hilo_md_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// HI/LO multiply-divide unit: shared op codes and counter sizing.
package hilo_pkg;

  localparam logic [3:0] HILO_NONE  = 4'd0;
  localparam logic [3:0] HILO_MULT  = 4'd1;
  localparam logic [3:0] HILO_MULTU = 4'd2;
  localparam logic [3:0] HILO_DIV   = 4'd3;
  localparam logic [3:0] HILO_DIVU  = 4'd4;
  localparam logic [3:0] HILO_MFHI  = 4'd5;
  localparam logic [3:0] HILO_MFLO  = 4'd6;
  localparam logic [3:0] HILO_MTHI  = 4'd7;
  localparam logic [3:0] HILO_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic int unsigned cnt_bits(
    input int unsigned m,
    input int unsigned d
  );
    int unsigned mx;
    mx = (m > d) ? m : d;
    return $clog2(mx + 1);
  endfunction

  localparam int unsigned CNT_W =
    cnt_bits(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/md_datapath.sv
// Combinational mult/div result generator for the HI/LO unit.
// Result packs as {HI, LO}.
module md_datapath
  import hilo_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] res64,
  output logic        div_by_zero
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic               ovf;
  logic               is_div;

  assign sa = {{32{A[31]}}, A};
  assign sb = {{32{B[31]}}, B};

  assign is_div = (op == HILO_DIV) || (op == HILO_DIVU);
  assign div_by_zero = is_div && (B == 32'd0);

  // most-negative / -1 overflows; pin the architectural answer
  assign ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (B != 32'd0) begin
      uq = A / B;
      ur = A % B;
      if (ovf) begin
        sq = 32'h8000_0000;
        sr = '0;
      end else begin
        sq = $signed(A) / $signed(B);
        sr = $signed(A) % $signed(B);
      end
    end
  end

  always_comb begin
    res64 = '0;
    unique case (1'b1)
      (op == HILO_MULT):  res64 = sa * sb;
      (op == HILO_MULTU): res64 = {32'd0, A} * {32'd0, B};
      (op == HILO_DIV):   res64 = {sr, sq};
      (op == HILO_DIVU):  res64 = {ur, uq};
      default:            res64 = '0;
    endcase
  end

endmodule

// File: rtl/hilo_md_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Fixed-latency ops; HILO_busy drives the stall logic.
module hilo_md_unit
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  HILO_Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        HILO_busy,
  output logic [31:0] HILO_out
);

  localparam int unsigned CW = cnt_bits(MULT_CYCLES, DIV_CYCLES);

  logic [CW-1:0] cnt;
  logic [63:0]   res64;
  logic [63:0]   dp_res;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic          dz;
  logic          is_mul;
  logic          is_md;
  logic          accept;

  md_datapath u_dp (
    .op          (HILO_Op),
    .A           (A),
    .B           (B),
    .res64       (dp_res),
    .div_by_zero (dz)
  );

  assign HILO_busy = (cnt != '0);
  assign is_mul = (HILO_Op == HILO_MULT) || (HILO_Op == HILO_MULTU);
  assign is_md  = is_mul ||
                  (HILO_Op == HILO_DIV) || (HILO_Op == HILO_DIVU);
  assign accept = start && is_md && !HILO_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      res64 <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      // divide by zero writes back the current HI/LO unchanged
      res64 <= dz ? {hi, lo} : dp_res;
      cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (HILO_busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= res64[63:32];
        lo <= res64[31:0];
      end
    end else begin
      if (HILO_Op == HILO_MTHI) hi <= A;
      if (HILO_Op == HILO_MTLO) lo <= A;
    end
  end

  always_comb begin
    HILO_out = '0;
    unique case (1'b1)
      (HILO_Op == HILO_MFHI): HILO_out = hi;
      (HILO_Op == HILO_MFLO): HILO_out = lo;
      default:                HILO_out = '0;
    endcase
  end

  a_no_start_busy: assert property (
    @(posedge clk) disable iff (!reset)
    HILO_busy |-> !start);

  a_no_mt_busy: assert property (
    @(posedge clk) disable iff (!reset)
    HILO_busy |-> !((HILO_Op == HILO_MTHI) ||
                    (HILO_Op == HILO_MTLO)));

  a_start_op: assert property (
    @(posedge clk) disable iff (!reset)
    start |-> is_md);

endmodule

// File: tb/tb_hilo_md_unit.sv
// Scoreboard bench for hilo_md_unit: directed mult/div/mt/mf
// vectors; monitor checks reads and busy-run lengths.
module tb_hilo_md_unit;
  import hilo_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  HILO_Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HILO_busy;
  logic [31:0] HILO_out;

  int errors = 0;
  int checks = 0;
  int run_len = 0;

  logic [31:0] rd_q[$];
  int          busy_q[$];

  hilo_md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .HILO_Op   (HILO_Op),
    .A         (A),
    .B         (B),
    .HILO_busy (HILO_busy),
    .HILO_out  (HILO_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // monitor: every MF read and every completed busy run is scored
  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
    end else begin
      if (HILO_Op == HILO_MFHI || HILO_Op == HILO_MFLO) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else check("hilo_read", HILO_out, rd_q.pop_front());
      end
      if (HILO_busy) begin
        run_len++;
      end else if (run_len > 0) begin
        if (busy_q.size() == 0) fail_now("busy_unexpected");
        else check("busy_len", 32'(run_len), 32'(busy_q.pop_front()));
        run_len = 0;
      end
    end
  end

  task automatic start_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    HILO_Op = op;
    A = a;
    B = b;
    if (n > 0) busy_q.push_back(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    HILO_Op = HILO_NONE;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk);
    #1;
    HILO_Op = op;
    A = a;
    @(posedge clk);
    #1;
    HILO_Op = HILO_NONE;
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] exp);
    @(posedge clk);
    #1;
    rd_q.push_back(exp);
    HILO_Op = op;
    @(posedge clk);
    #1;
    HILO_Op = HILO_NONE;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (HILO_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (HILO_busy) fail_now("busy_timeout");
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    HILO_Op = HILO_NONE;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(HILO_busy), 32'd0);
    HILO_Op = HILO_MFHI;
    #1 check("rst_hi", HILO_out, 32'd0);
    HILO_Op = HILO_MFLO;
    #1 check("rst_lo", HILO_out, 32'd0);
    HILO_Op = HILO_NONE;
    reset = 1'b1;

    // signed and unsigned multiply
    start_op(HILO_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    wait_idle();
    rd(HILO_MFHI, 32'hFFFF_FFFF);
    rd(HILO_MFLO, 32'hFFFF_FFFA);

    start_op(HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    wait_idle();
    rd(HILO_MFHI, 32'hFFFF_FFFE);
    rd(HILO_MFLO, 32'h0000_0001);

    // signed and unsigned divide
    start_op(HILO_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    wait_idle();
    rd(HILO_MFLO, 32'hFFFF_FFFD);
    rd(HILO_MFHI, 32'hFFFF_FFFF);

    start_op(HILO_DIVU, 32'hFFFF_FFF9, 32'd2, 10);
    wait_idle();
    rd(HILO_MFLO, 32'h7FFF_FFFC);
    rd(HILO_MFHI, 32'h0000_0001);

    // MT writes, then divide by zero leaves HI/LO alone
    mt(HILO_MTHI, 32'h0000_1234);
    mt(HILO_MTLO, 32'h0000_5678);
    start_op(HILO_DIVU, 32'd99, 32'd0, 10);
    wait_idle();
    rd(HILO_MFHI, 32'h0000_1234);
    rd(HILO_MFLO, 32'h0000_5678);

    // unused op codes read as zero
    @(posedge clk);
    #1 HILO_Op = 4'd9;
    #1 check("op9_out", HILO_out, 32'd0);
    HILO_Op = 4'd15;
    #1 check("op15_out", HILO_out, 32'd0);
    HILO_Op = HILO_NONE;

    // reset in the middle of a multiply
    start_op(HILO_MULT, 32'd2, 32'd3, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1 check("midrst_busy", 32'(HILO_busy), 32'd0);
    HILO_Op = HILO_MFHI;
    #1 check("midrst_hi", HILO_out, 32'd0);
    HILO_Op = HILO_MFLO;
    #1 check("midrst_lo", HILO_out, 32'd0);
    HILO_Op = HILO_NONE;
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("postrst_busy", 32'(HILO_busy), 32'd0);
    rd(HILO_MFHI, 32'd0);
    rd(HILO_MFLO, 32'd0);

    // back-to-back: DIV accepted on the first idle cycle
    start_op(HILO_MULT, 32'h0001_0001, 32'h0001_0001, 5);
    wait_idle();
    start = 1'b1;
    HILO_Op = HILO_DIV;
    A = 32'h8000_0000;
    B = 32'hFFFF_FFFF;
    busy_q.push_back(10);
    @(posedge clk);
    #1;
    start = 1'b0;
    HILO_Op = HILO_NONE;
    @(negedge clk);
    check("b2b_busy", 32'(HILO_busy), 32'd1);
    rd(HILO_MFLO, 32'h0002_0001);
    rd(HILO_MFHI, 32'h0000_0001);
    wait_idle();
    rd(HILO_MFLO, 32'h8000_0000);
    rd(HILO_MFHI, 32'h0000_0000);

    repeat (3) @(posedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("busy_q_drained", 32'(busy_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
